// File: rtl/gpio_irq_cond_pkg.sv
// Shared types and helpers for the GPIO/IRQ input conditioner.
// Edge-mode encoding matches the per-channel two-bit field of edge_mode_i.
package gpio_irq_cond_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // Counter width able to hold 0..cycles; a single-cycle debounce still needs one bit.
  function automatic int cnt_width(int cycles);
    if (cycles < 1) return 1;
    return $clog2(cycles + 1);
  endfunction

  // True when an accepted edge is one the channel's mode asks to latch.
  function automatic logic edge_hit(edge_mode_t mode, logic rise, logic fall);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/gpio_irq_cond_debounce_chan.sv
// One conditioner channel: synchroniser, stability counter, debounced level
// and single-cycle rise/fall pulses coincident with the level change.
module debounce_chan
  import gpio_irq_cond_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 100000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt_q;
  logic                   accept;

  assign s      = sync_q[SYNC_STAGES-1];
  assign accept = (s != level) && (cnt_q == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Any sample equal to the current level restarts the count, so glitches
  // shorter than DEBOUNCE_CYCLES never reach the terminal compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      level <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= accept & s;
      fall <= accept & ~s;
      if (s == level) begin
        cnt_q <= '0;
      end else if (accept) begin
        level <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_irq_cond.sv
// N-channel pin conditioner: per-channel debounce plus sticky, write-1-to-clear
// interrupt-pending bits reduced to a single registered IRQ line.
module gpio_irq_cond
  import gpio_irq_cond_pkg::*;
#(
  parameter int   NUM_CH          = 16,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 100000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic [NUM_CH-1:0]     raw_i,
  input  logic [2*NUM_CH-1:0]   edge_mode_i,
  input  logic [NUM_CH-1:0]     irq_clr_i,
  output logic [NUM_CH-1:0]     level_o,
  output logic [NUM_CH-1:0]     rise_o,
  output logic [NUM_CH-1:0]     fall_o,
  output logic [NUM_CH-1:0]     pending_o,
  output logic                  irq_o
);

  logic [NUM_CH-1:0] pend_set;
  logic [NUM_CH-1:0] pend_next;
  logic [NUM_CH-1:0] pending_q;
  logic              irq_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL)
    ) u_chan (
      .clk   (clk_i),
      .rst   (arst_i),
      .raw   (raw_i[k]),
      .level (level_o[k]),
      .rise  (rise_o[k]),
      .fall  (fall_o[k])
    );
  end

  // Pending sets on the edge after the visible rise/fall pulse, using the mode
  // present during that pulse cycle; a set beats a same-cycle clear.
  always_comb begin
    pend_set = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pend_set[k] = edge_hit(edge_mode_t'(edge_mode_i[2*k +: 2]), rise_o[k], fall_o[k]);
    end
    pend_next = (pending_q & ~irq_clr_i) | pend_set;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pend_next;
      irq_q     <= |pend_next;
    end
  end

  assign pending_o = pending_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_irq_cond.sv
// Directed bench for gpio_irq_cond with 4 channels, 2 sync stages, 4-cycle debounce.
module tb_gpio_irq_cond;

  localparam int NCH = 4;

  logic           clk;
  logic           arst;
  logic [NCH-1:0] raw;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0] clr;
  logic [NCH-1:0] level;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic [NCH-1:0] pending;
  logic           irq;

  int checks;
  int errors;
  logic seen;

  gpio_irq_cond #(
    .NUM_CH          (NCH),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_LEVEL     (1'b0)
  ) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .raw_i       (raw),
    .edge_mode_i (mode),
    .irq_clr_i   (clr),
    .level_o     (level),
    .rise_o      (rise),
    .fall_o      (fall),
    .pending_o   (pending),
    .irq_o       (irq)
  );

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n edges; inputs are driven and outputs sampled 1 ns after each edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    arst   = 1'b1;
    raw    = '0;
    mode   = '0;
    clr    = '0;

    // reset state
    tick(3);
    check("rst_level",   32'(level),   32'h0);
    check("rst_rise",    32'(rise),    32'h0);
    check("rst_fall",    32'(fall),    32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_irq",     32'(irq),     32'h0);
    arst = 1'b0;
    tick(3);

    // clean step on ch0, mode rise
    mode[1:0] = 2'b01;
    raw[0]    = 1'b1;
    tick(5);
    check("step_level_early", 32'(level), 32'h0);
    tick(1);
    check("step_level", 32'(level), 32'h1);
    check("step_rise",  32'(rise),  32'h1);
    check("step_fall",  32'(fall),  32'h0);
    tick(1);
    check("step_rise_one_cycle", 32'(rise),    32'h0);
    check("step_pending",        32'(pending), 32'h1);
    check("step_irq",            32'(irq),     32'h1);
    clr = 4'b0001;
    tick(1);
    clr = '0;
    check("clr0_pending", 32'(pending), 32'h0);
    check("clr0_irq",     32'(irq),     32'h0);

    // glitch of 3 cycles on ch1 (mode both) must never be accepted
    mode[3:2] = 2'b11;
    raw[1]    = 1'b1;
    tick(3);
    raw[1] = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen = seen | level[1] | rise[1] | pending[1];
    end
    check("glitch_reject", 32'(seen), 32'h0);

    // ch2 fall-only mode: rise ignored, fall latched
    mode[5:4] = 2'b10;
    raw[2]    = 1'b1;
    tick(6);
    check("ch2_rise", 32'(rise), 32'h4);
    tick(4);
    check("ch2_level_hi",     32'(level),   32'h5);
    check("ch2_no_pend_rise", 32'(pending), 32'h0);
    raw[2] = 1'b0;
    tick(6);
    check("ch2_fall",     32'(fall),    32'h4);
    check("ch2_level_lo", 32'(level),   32'h1);
    check("ch2_pend_pre", 32'(pending), 32'h0);
    tick(1);
    check("ch2_pending", 32'(pending), 32'h4);
    check("ch2_irq",     32'(irq),     32'h1);
    clr = 4'b0100;
    tick(1);
    clr = '0;
    check("ch2_cleared", 32'(pending), 32'h0);

    // mode 00 on ch3: pulse appears, pending stays clear
    mode[7:6] = 2'b00;
    raw[3]    = 1'b1;
    tick(6);
    check("m00_rise", 32'(rise), 32'h8);
    tick(1);
    check("m00_pending", 32'(pending), 32'h0);
    check("m00_irq",     32'(irq),     32'h0);

    // set/clear collision on ch3 (mode rise)
    mode[7:6] = 2'b01;
    raw[3]    = 1'b0;
    tick(6);
    check("col_fall", 32'(fall), 32'h8);
    tick(1);
    check("col_fall_no_pend", 32'(pending), 32'h0);
    raw[3] = 1'b1;
    tick(6);
    check("col_rise1", 32'(rise), 32'h8);
    tick(1);
    check("col_pend1", 32'(pending), 32'h8);
    raw[3] = 1'b0;
    tick(6);
    tick(1);
    raw[3] = 1'b1;
    tick(6);
    check("col_rise2", 32'(rise), 32'h8);
    clr = 4'b1000;
    tick(1);
    clr = '0;
    check("col_set_wins", 32'(pending), 32'h8);
    check("col_irq",      32'(irq),     32'h1);
    clr = 4'b1000;
    tick(1);
    clr = '0;
    check("col_cleared", 32'(pending), 32'h0);
    check("col_irq_lo",  32'(irq),     32'h0);

    // return all pins low; ch0/ch3 falls are not latched in rise mode
    raw = '0;
    tick(8);
    check("idle_level",   32'(level),   32'h0);
    check("idle_pending", 32'(pending), 32'h0);

    // reset two cycles into the ch0 debounce count
    raw[0] = 1'b1;
    tick(4);
    arst = 1'b1;
    #1;
    check("mrst_level",   32'(level),   32'h0);
    check("mrst_rise",    32'(rise),    32'h0);
    check("mrst_pending", 32'(pending), 32'h0);
    check("mrst_irq",     32'(irq),     32'h0);
    tick(2);
    arst = 1'b0;
    tick(5);
    check("mrst_level_early", 32'(level), 32'h0);
    tick(1);
    check("mrst_rise_late", 32'(rise),  32'h1);
    check("mrst_level_hi",  32'(level), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen = seen | rise[0];
    end
    check("mrst_single_rise", 32'(seen),    32'h0);
    check("mrst_pending",     32'(pending), 32'h1);
    clr = 4'b0001;
    tick(1);
    clr = '0;
    raw = '0;
    tick(8);
    check("pre_multi_pending", 32'(pending), 32'h0);

    // all four channels step together in mode both
    mode = 8'hFF;
    raw  = 4'hF;
    tick(6);
    check("multi_rise",  32'(rise),  32'hF);
    check("multi_level", 32'(level), 32'hF);
    tick(1);
    check("multi_pending", 32'(pending), 32'hF);
    check("multi_irq",     32'(irq),     32'h1);
    clr = 4'h5;
    tick(1);
    clr = '0;
    check("multi_clr_pending", 32'(pending), 32'hA);
    check("multi_clr_irq",     32'(irq),     32'h1);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_irq_cond.md
Name: gpio_irq_cond

Overview:
- Parametrised N-channel input conditioner between the board pins (slide switches, push buttons) and the sigma GPIO/IRQ inputs.
- Generalises the single raw-button IRQ path to N channels. Each channel gets a metastability synchroniser, a debouncer, rise/fall pulse generation and a per-channel edge-mode select.
- Sticky interrupt-pending bits with write-1-to-clear, OR-reduced to one IRQ line.
- Debounced levels feed gpio_bi; irq_o replaces the raw irq_btn_i connection.

Parameters:
- NUM_CH, 16: number of input channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- DEBOUNCE_CYCLES, 100000: consecutive stable samples required to accept a change (>=1); 1 ms at 100 MHz.
- RESET_LEVEL, 1'b0: reset value of synchroniser flops and debounced level.

Ports:
- clk_i  in  1  system clock (PLL output)
- arst_i  in  1  asynchronous reset, active-high
- raw_i  in  NUM_CH  asynchronous pin inputs
- edge_mode_i  in  2*NUM_CH  per-channel IRQ source, bits [2k+1:2k]: 00 none, 01 rise, 10 fall, 11 both
- irq_clr_i  in  NUM_CH  write-1-to-clear pending bits, single-cycle strobe per bit
- level_o  out  NUM_CH  debounced level
- rise_o  out  NUM_CH  one-cycle pulse on accepted 0->1
- fall_o  out  NUM_CH  one-cycle pulse on accepted 1->0
- pending_o  out  NUM_CH  sticky pending bits
- irq_o  out  1  OR of pending_o, registered

Behaviour:
- Reset (async assert, sync deassert supplied by the board top):
  - sync chain, level_o = RESET_LEVEL
  - counters = 0
  - rise_o, fall_o, pending_o, irq_o = 0
- Synchroniser: raw_i passes through SYNC_STAGES flops; the last stage is s.
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
  - s == level: counter <= 0.
  - s != level and counter == DEBOUNCE_CYCLES-1: level <= s, counter <= 0.
  - Otherwise counter += 1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes level. Any return to level restarts the count.
- Latency: a clean step on raw_i reaches level_o exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles after the first sampling edge.
- rise_o/fall_o:
  - Asserted in the same cycle level_o changes, for exactly one cycle.
  - Registered outputs; never both high.
- Pending set condition, per channel: (rise & mode[0]) | (fall & mode[1]), using edge_mode_i sampled in the same cycle as the pulse.
- Pending update: pending <= (pending & ~irq_clr_i) | set. Set wins over a simultaneous clear of the same bit.
- irq_o: registered OR of next-cycle pending, so irq_o follows pending_o with zero extra latency (both registers update on the same edge).
- Changing edge_mode_i to 00 does not clear already-pending bits.
- Reset mid-debounce: the count is discarded and no pulse is emitted.
  - An input held at ~RESET_LEVEL through reset produces one accepted edge SYNC_STAGES + DEBOUNCE_CYCLES cycles after deassert.
  - This is intended: firmware must clear pending at boot.
- Counter never wraps: it is bounded by the terminal compare.

Decomposition:
- Package gpio_irq_cond_pkg:
  - typedef enum logic [1:0] edge_mode_t {EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH}
  - function cnt_width(int cycles)
- Sub-module debounce_chan: one channel of synchroniser, counter, level, rise/fall. It takes SYNC_STAGES, DEBOUNCE_CYCLES and RESET_LEVEL, and is generated NUM_CH times.
- The top holds the pending logic and the irq reduction.

Test Plan (bench uses NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Clean step: raw_i[0] 0->1 held -> level_o[0]=1 and rise_o[0]=1 for one cycle exactly 6 cycles later; fall_o stays 0.
- Glitch reject: raw_i[1] high for 3 cycles then low -> level_o[1], rise_o[1] and pending_o[1] stay 0 indefinitely.
- Edge modes:
  - edge_mode_i = 2'b10 on ch2, toggle 0->1->0 with 10-cycle holds -> pending_o[2] set only after the fall, irq_o=1.
  - Mode 00 -> pulses still appear, pending never sets.
- Set/clear collision: with pending_o[3]=1, pulse irq_clr_i[3] in the same cycle a new rise on ch3 -> pending_o[3] remains 1.
  - Next cycle with clear only -> pending_o[3]=0 and irq_o=0.
- Reset mid-operation: assert arst_i 2 cycles into a debounce on ch0 -> all outputs 0 immediately.
  - With raw_i[0] still high after deassert -> single rise 6 cycles later.
- Multi-channel: simultaneous steps on all 4 channels with mode 11 -> four rise pulses in the same cycle, pending_o=4'hF; clearing 4'h5 leaves 4'hA, irq_o=1.
